hazard_ctrl: RTL and testbench

//  Pipeline hazard controller; produces the stall/bubble/flush controls that the ID/EX and IF/ID

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / branch-redirect hazard controller driving ID/EX, IF/ID and PC.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
//
// Ports:
//   clk, rst                clock, synchronous active-low reset
//   idRegSrc1/2, idUseRs1/2 source operands of the instruction in ID
//   exLoad, exRegWrite      kind of the instruction in EX
//   exRegDes                destination register of the instruction in EX
//   exBranchTaken           EX redirects the PC
//   LoadStall               bubble into ID/EX this edge
//   pcStall, ifidStall      hold PC / hold IF/ID
//   ifidFlush               clear IF/ID to nop
//   hazState                0 RUN, 1 LDSTALL, 2 FLUSH
//   perfStallCnt/FlushCnt   saturating event counters (0 when disabled)
module hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  idRegSrc1,
   input  logic [4:0]  idRegSrc2,
   input  logic        idUseRs1,
   input  logic        idUseRs2,
   input  logic        exLoad,
   input  logic        exRegWrite,
   input  logic [4:0]  exRegDes,
   input  logic        exBranchTaken,
   output logic        LoadStall,
   output logic        pcStall,
   output logic        ifidStall,
   output logic        ifidFlush,
   output logic [1:0]  hazState,
   output logic [31:0] perfStallCnt,
   output logic [31:0] perfFlushCnt
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   localparam logic [2:0] LD_LOAD = 3'(LOAD_STALL_CYCLES - 1);
   localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       lu_haz;

   assign lu_haz = exLoad && exRegWrite && (exRegDes != 5'd0) &&
                   ((idUseRs1 && (idRegSrc1 == exRegDes)) ||
                    (idUseRs2 && (idRegSrc2 == exRegDes)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (exBranchTaken) begin
         // a redirect overrides any window in progress
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FL_LOAD;
         end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (lu_haz && (LOAD_STALL_CYCLES > 1)) begin
                  state_d = LDSTALL;
                  cnt_d   = LD_LOAD;
               end
            end
            LDSTALL, FLUSH: begin
               if (cnt_q == 3'd1) begin
                  state_d = RUN;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_comb begin
      LoadStall = 1'b0;
      pcStall   = 1'b0;
      ifidStall = 1'b0;
      ifidFlush = 1'b0;
      hazState  = 2'd0;
      if (rst) begin
         hazState = state_q;
         if (exBranchTaken) begin
            LoadStall = 1'b1;
            ifidFlush = 1'b1;
         end else if (state_q == FLUSH) begin
            ifidFlush = 1'b1;
         end else if (state_q == LDSTALL || lu_haz) begin
            LoadStall = 1'b1;
            pcStall   = 1'b1;
            ifidStall = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pcStall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (ifidFlush && (flush_cnt_q != 32'hFFFF_FFFF))
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perfStallCnt = rst ? stall_cnt_q : 32'd0;
   assign perfFlushCnt = rst ? flush_cnt_q : 32'd0;
`else
   assign perfStallCnt = 32'd0;
   assign perfFlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations checked against a window model.
// Instance a: 1/1 cycles, instance b: 3 stall / 2 flush cycles.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic [4:0] idRegSrc1 = '0, idRegSrc2 = '0, exRegDes = '0;
   logic       idUseRs1 = 0, idUseRs2 = 0, exLoad = 0;
   logic       exRegWrite = 0, exBranchTaken = 0;

   logic        a_ls, a_pc, a_is, a_if, b_ls, b_pc, b_is, b_if;
   logic [1:0]  a_st, b_st;
   logic [31:0] a_ps, a_pf, b_ps, b_pf;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst),
      .idRegSrc1(idRegSrc1), .idRegSrc2(idRegSrc2),
      .idUseRs1(idUseRs1), .idUseRs2(idUseRs2),
      .exLoad(exLoad), .exRegWrite(exRegWrite),
      .exRegDes(exRegDes), .exBranchTaken(exBranchTaken),
      .LoadStall(a_ls), .pcStall(a_pc), .ifidStall(a_is),
      .ifidFlush(a_if), .hazState(a_st),
      .perfStallCnt(a_ps), .perfFlushCnt(a_pf)
   );

   hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst),
      .idRegSrc1(idRegSrc1), .idRegSrc2(idRegSrc2),
      .idUseRs1(idUseRs1), .idUseRs2(idUseRs2),
      .exLoad(exLoad), .exRegWrite(exRegWrite),
      .exRegDes(exRegDes), .exBranchTaken(exBranchTaken),
      .LoadStall(b_ls), .pcStall(b_pc), .ifidStall(b_is),
      .ifidFlush(b_if), .hazState(b_st),
      .perfStallCnt(b_ps), .perfFlushCnt(b_pf)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // Model: each hazard opens a window [start, until) of cycle numbers.
   int     ld[2] = '{1, 3};
   int     fl[2] = '{1, 2};
   longint cyc = 0;
   longint su[2] = '{0, 0};
   longint fu[2] = '{0, 0};
   longint ps[2] = '{0, 0};
   longint pf[2] = '{0, 0};

   function automatic bit lu();
      return exLoad && exRegWrite && exRegDes != 0 &&
             ((idUseRs1 && idRegSrc1 == exRegDes) ||
              (idUseRs2 && idRegSrc2 == exRegDes));
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit     e_ls, e_pc, e_if;
         int     e_st;
         longint e_ps, e_pf;
         string  p;
         e_ls = 0;
         e_pc = 0;
         e_if = 0;
         e_st = (cyc < fu[k]) ? 2 : (cyc < su[k]) ? 1 : 0;
         e_ps = PERF ? ps[k] : 0;
         e_pf = PERF ? pf[k] : 0;
         if (!rst) begin
            e_st = 0;
            e_ps = 0;
            e_pf = 0;
            su[k] = 0;
            fu[k] = 0;
         end else if (exBranchTaken) begin
            e_ls = 1;
            e_if = 1;
            fu[k] = cyc + fl[k];
            su[k] = 0;
         end else if (cyc < fu[k]) begin
            e_if = 1;
         end else if (cyc < su[k]) begin
            e_ls = 1;
            e_pc = 1;
         end else if (lu()) begin
            e_ls = 1;
            e_pc = 1;
            su[k] = cyc + ld[k];
         end
         p = (k == 0) ? "a" : "b";
         if (k == 0) begin
            chk({p, ".LoadStall"}, 32'(a_ls), 32'(e_ls));
            chk({p, ".pcStall"},   32'(a_pc), 32'(e_pc));
            chk({p, ".ifidStall"}, 32'(a_is), 32'(e_pc));
            chk({p, ".ifidFlush"}, 32'(a_if), 32'(e_if));
            chk({p, ".hazState"},  32'(a_st), 32'(e_st));
            chk({p, ".perfStall"}, a_ps, 32'(e_ps));
            chk({p, ".perfFlush"}, a_pf, 32'(e_pf));
         end else begin
            chk({p, ".LoadStall"}, 32'(b_ls), 32'(e_ls));
            chk({p, ".pcStall"},   32'(b_pc), 32'(e_pc));
            chk({p, ".ifidStall"}, 32'(b_is), 32'(e_pc));
            chk({p, ".ifidFlush"}, 32'(b_if), 32'(e_if));
            chk({p, ".hazState"},  32'(b_st), 32'(e_st));
            chk({p, ".perfStall"}, b_ps, 32'(e_ps));
            chk({p, ".perfFlush"}, b_pf, 32'(e_pf));
         end
         if (!rst) begin
            ps[k] = 0;
            pf[k] = 0;
         end else begin
            if (e_pc && ps[k] < 64'hFFFF_FFFF) ps[k]++;
            if (e_if && pf[k] < 64'hFFFF_FFFF) pf[k]++;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      idRegSrc1 = 0; idRegSrc2 = 0; exRegDes = 0;
      idUseRs1 = 0; idUseRs2 = 0; exLoad = 0;
      exRegWrite = 0; exBranchTaken = 0;
   endtask

   task automatic haz();
      exLoad = 1; exRegWrite = 1; exRegDes = 5;
      idRegSrc1 = 5; idUseRs1 = 1;
   endtask

   initial begin
      rst = 0;
      tick();
      tick();
      haz();
      #1;
      chk("rst.a_ls_forced", 32'(a_ls), 0);
      chk("rst.b_pc_forced", 32'(b_pc), 0);
      chk("rst.b_st", 32'(b_st), 0);
      idle();
      rst = 1;
      tick();

      // case 1
      haz();
      #1;
      chk("c1.a_ls", 32'(a_ls), 1);
      chk("c1.a_pc", 32'(a_pc), 1);
      chk("c1.a_is", 32'(a_is), 1);
      tick();
      idle();
      #1;
      chk("c1.a_ls_next", 32'(a_ls), 0);
      chk("c1.a_pc_next", 32'(a_pc), 0);
      tick();
      tick();

      // case 2
      haz();
      exRegDes = 0;
      idRegSrc1 = 0;
      #1;
      chk("c2.a_ls_rd0", 32'(a_ls), 0);
      chk("c2.b_ls_rd0", 32'(b_ls), 0);
      tick();
      haz();
      idUseRs1 = 0;
      #1;
      chk("c2.a_pc_nouse", 32'(a_pc), 0);
      chk("c2.b_st", 32'(b_st), 0);
      tick();
      idle();
      idUseRs2 = 1;
      idRegSrc2 = 7;
      exRegDes = 7;
      exLoad = 1;
      exRegWrite = 1;
      #1;
      chk("c2.a_ls_rs2", 32'(a_ls), 1);
      idle();
      rst = 0;
      tick();
      rst = 1;
      tick();

      // case 3
      haz();
      #1;
      chk("c3.b_pc1", 32'(b_pc), 1);
      chk("c3.b_st1", 32'(b_st), 0);
      tick();
      idle();
      #1;
      chk("c3.b_pc2", 32'(b_pc), 1);
      chk("c3.b_st2", 32'(b_st), 1);
      tick();
      #1;
      chk("c3.b_pc3", 32'(b_pc), 1);
      chk("c3.b_st3", 32'(b_st), 1);
      tick();
      #1;
      chk("c3.b_pc4", 32'(b_pc), 0);
      chk("c3.b_st4", 32'(b_st), 0);
      tick();

      // case 4
      haz();
      exBranchTaken = 1;
      #1;
      chk("c4.b_ls1", 32'(b_ls), 1);
      chk("c4.b_if1", 32'(b_if), 1);
      chk("c4.b_pc1", 32'(b_pc), 0);
      chk("c4.b_is1", 32'(b_is), 0);
      tick();
      idle();
      #1;
      chk("c4.b_if2", 32'(b_if), 1);
      chk("c4.b_ls2", 32'(b_ls), 0);
      chk("c4.b_st2", 32'(b_st), 2);
      chk("c4.a_if2", 32'(a_if), 0);
      tick();
      #1;
      chk("c4.b_if3", 32'(b_if), 0);
      chk("c4.b_st3", 32'(b_st), 0);

      // case 6
      chk("c6.b_perf_stall", b_ps, PERF ? 3 : 0);
      chk("c6.b_perf_flush", b_pf, PERF ? 2 : 0);
      chk("c6.a_perf_stall", a_ps, PERF ? 1 : 0);
      tick();

      // case 5
      haz();
      tick();
      idle();
      rst = 0;
      #1;
      chk("c5.b_pc_rst", 32'(b_pc), 0);
      chk("c5.b_ls_rst", 32'(b_ls), 0);
      tick();
      rst = 1;
      #1;
      chk("c5.b_st_after", 32'(b_st), 0);
      chk("c5.b_pc_after", 32'(b_pc), 0);
      tick();
      #1;
      chk("c5.b_pc_late", 32'(b_pc), 0);
      tick();

      // branch overrides a stall window
      haz();
      tick();
      idle();
      exBranchTaken = 1;
      #1;
      chk("ov.b_pc", 32'(b_pc), 0);
      chk("ov.b_if", 32'(b_if), 1);
      tick();
      idle();
      #1;
      chk("ov.b_st", 32'(b_st), 2);
      tick();

      // back-to-back redirects reload the flush window
      exBranchTaken = 1;
      tick();
      haz();
      exBranchTaken = 1;
      tick();
      idle();
      haz();
      #1;
      chk("rl.b_st", 32'(b_st), 2);
      chk("rl.b_pc", 32'(b_pc), 0);
      tick();
      idle();

      // mixed sweep, checked by the model only
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 39) != 0);
         idRegSrc1 = 5'($urandom_range(0, 3));
         idRegSrc2 = 5'($urandom_range(0, 3));
         exRegDes = 5'($urandom_range(0, 3));
         idUseRs1 = 1'($urandom_range(0, 1));
         idUseRs2 = 1'($urandom_range(0, 1));
         exLoad = 1'($urandom_range(0, 1));
         exRegWrite = ($urandom_range(0, 3) != 0);
         exBranchTaken = ($urandom_range(0, 7) == 0);
         tick();
      end
      idle();
      rst = 1;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
